reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 59 +++++
 rtl/reorder_buffer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_pkg.sv
// Reorder buffer shared definitions.
// Opcode codes, sizing and opcode class helpers.
package reorder_buffer_pkg;

  localparam int RoB_WIDTH = 8;
  localparam int NON_DEP   = 1 << RoB_WIDTH;

  localparam logic [6:0] OP_LUI   = 7'd1;
  localparam logic [6:0] OP_AUIPC = 7'd2;
  localparam logic [6:0] OP_JAL   = 7'd3;
  localparam logic [6:0] OP_JALR  = 7'd4;
  localparam logic [6:0] OP_BEQ   = 7'd5;
  localparam logic [6:0] OP_BNE   = 7'd6;
  localparam logic [6:0] OP_BLT   = 7'd7;
  localparam logic [6:0] OP_BGE   = 7'd8;
  localparam logic [6:0] OP_BLTU  = 7'd9;
  localparam logic [6:0] OP_BGEU  = 7'd10;
  localparam logic [6:0] OP_LB    = 7'd11;
  localparam logic [6:0] OP_LH    = 7'd12;
  localparam logic [6:0] OP_LW    = 7'd13;
  localparam logic [6:0] OP_LBU   = 7'd14;
  localparam logic [6:0] OP_LHU   = 7'd15;
  localparam logic [6:0] OP_SB    = 7'd16;
  localparam logic [6:0] OP_SH    = 7'd17;
  localparam logic [6:0] OP_SW    = 7'd18;
  localparam logic [6:0] OP_ADDI  = 7'd19;
  localparam logic [6:0] OP_SLTI  = 7'd20;
  localparam logic [6:0] OP_SLTIU = 7'd21;
  localparam logic [6:0] OP_XORI  = 7'd22;
  localparam logic [6:0] OP_ORI   = 7'd23;
  localparam logic [6:0] OP_ANDI  = 7'd24;
  localparam logic [6:0] OP_SLLI  = 7'd25;
  localparam logic [6:0] OP_SRLI  = 7'd26;
  localparam logic [6:0] OP_SRAI  = 7'd27;
  localparam logic [6:0] OP_ADD   = 7'd28;
  localparam logic [6:0] OP_SUB   = 7'd29;
  localparam logic [6:0] OP_SLL   = 7'd30;
  localparam logic [6:0] OP_SLT   = 7'd31;
  localparam logic [6:0] OP_SLTU  = 7'd32;
  localparam logic [6:0] OP_XORR  = 7'd33;
  localparam logic [6:0] OP_SRL   = 7'd34;
  localparam logic [6:0] OP_SRA   = 7'd35;
  localparam logic [6:0] OP_ORR   = 7'd36;
  localparam logic [6:0] OP_ANDD  = 7'd37;

  function automatic logic is_branch(input logic [6:0] op);
    return (op >= OP_BEQ) && (op <= OP_BGEU);
  endfunction

  function automatic logic is_store(input logic [6:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  // Jumps and branches: anything that carries a predicted pc.
  function automatic logic is_ctrl(input logic [6:0] op);
    return (op >= OP_JAL) && (op <= OP_BGEU);
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocate and commit,
// out-of-order completion, mispredict flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int RoB_WIDTH  = 8,
  parameter int RoB_SIZE   = 1 << RoB_WIDTH,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic                  DPRoB_en,
  input  logic [ADDR_WIDTH-1:0] DPRoB_pc,
  input  logic [ADDR_WIDTH-1:0] DPRoB_pred_pc,
  input  logic [6:0]            DPRoB_opcode,
  input  logic [4:0]            DPRoB_rd,
  output logic                  RoBDP_full,
  output logic [RoB_WIDTH-1:0]  RoBDP_RoB_index,
  input  logic                  RSCDB_en,
  input  logic [RoB_WIDTH-1:0]  RSCDB_RoB_index,
  input  logic [31:0]           RSCDB_value,
  input  logic [ADDR_WIDTH-1:0] RSCDB_next_pc,
  input  logic                  CDBRS_LSB_en,
  input  logic [RoB_WIDTH-1:0]  CDBRS_LSB_RoB_index,
  input  logic [31:0]           CDBRS_LSB_value,
  output logic                  RoBRF_en,
  output logic [4:0]            RoBRF_rd,
  output logic [31:0]           RoBRF_value,
  output logic [RoB_WIDTH-1:0]  RoBRF_RoB_index,
  output logic                  RoBLSB_commit_en,
  output logic [RoB_WIDTH-1:0]  RoBLSB_RoB_index,
  output logic                  RoBRS_pre_judge,
  output logic [ADDR_WIDTH-1:0] RoBIF_next_pc
);

  localparam int CW = RoB_WIDTH + 1;

  logic [RoB_SIZE-1:0]   busy_q;
  logic [RoB_SIZE-1:0]   rdy_q;
  logic [6:0]            op_q   [RoB_SIZE];
  logic [4:0]            rd_q   [RoB_SIZE];
  logic [31:0]           val_q  [RoB_SIZE];
  logic [ADDR_WIDTH-1:0] pred_q [RoB_SIZE];
  logic [ADDR_WIDTH-1:0] npc_q  [RoB_SIZE];

  logic [RoB_WIDTH-1:0] head_q, tail_q;
  logic [RoB_WIDTH-1:0] head_d, tail_d;
  logic [CW-1:0]        cnt_q;

  logic [6:0] h_op;
  logic       do_alloc, do_commit;
  logic       commit_rf, commit_st, mispred;
  logic       unused_pc;

  // The instruction pc is carried for debug only.
  assign unused_pc = ^DPRoB_pc;

  assign RoBDP_full      = (cnt_q == CW'(RoB_SIZE));
  assign RoBDP_RoB_index = tail_q;

  assign head_d = (head_q == RoB_WIDTH'(RoB_SIZE - 1))
                ? '0 : head_q + RoB_WIDTH'(1);
  assign tail_d = (tail_q == RoB_WIDTH'(RoB_SIZE - 1))
                ? '0 : tail_q + RoB_WIDTH'(1);

  assign h_op      = op_q[head_q];
  assign do_commit = RoBRS_pre_judge
                   && busy_q[head_q] && rdy_q[head_q];
  assign do_alloc  = RoBRS_pre_judge
                   && DPRoB_en && !RoBDP_full;
  assign commit_st = is_store(h_op);
  assign commit_rf = !is_branch(h_op) && !commit_st
                   && (rd_q[head_q] != 5'd0);
  assign mispred   = is_ctrl(h_op)
                   && (npc_q[head_q] != pred_q[head_q]);

  // Buffer state, completion, commit and flush.
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      head_q           <= '0;
      tail_q           <= '0;
      cnt_q            <= '0;
      busy_q           <= '0;
      rdy_q            <= '0;
      RoBRF_en         <= 1'b0;
      RoBRF_rd         <= '0;
      RoBRF_value      <= '0;
      RoBRF_RoB_index  <= '0;
      RoBLSB_commit_en <= 1'b0;
      RoBLSB_RoB_index <= '0;
      RoBRS_pre_judge  <= 1'b1;
      RoBIF_next_pc    <= '0;
    end else if (Sys_rdy) begin
      RoBRF_en         <= 1'b0;
      RoBRF_rd         <= '0;
      RoBRF_value      <= '0;
      RoBRF_RoB_index  <= '0;
      RoBLSB_commit_en <= 1'b0;
      RoBLSB_RoB_index <= '0;
      if (!RoBRS_pre_judge) begin
        busy_q          <= '0;
        head_q          <= '0;
        tail_q          <= '0;
        cnt_q           <= '0;
        RoBRS_pre_judge <= 1'b1;
      end else begin
        if (RSCDB_en && busy_q[RSCDB_RoB_index]) begin
          rdy_q[RSCDB_RoB_index] <= 1'b1;
          val_q[RSCDB_RoB_index] <= RSCDB_value;
          npc_q[RSCDB_RoB_index] <= RSCDB_next_pc;
        end
        if (CDBRS_LSB_en
            && busy_q[CDBRS_LSB_RoB_index]) begin
          rdy_q[CDBRS_LSB_RoB_index] <= 1'b1;
          val_q[CDBRS_LSB_RoB_index] <= CDBRS_LSB_value;
        end
        if (do_commit) begin
          busy_q[head_q] <= 1'b0;
          head_q         <= head_d;
          if (commit_rf) begin
            RoBRF_en        <= 1'b1;
            RoBRF_rd        <= rd_q[head_q];
            RoBRF_value     <= val_q[head_q];
            RoBRF_RoB_index <= head_q;
          end
          if (commit_st) begin
            RoBLSB_commit_en <= 1'b1;
            RoBLSB_RoB_index <= head_q;
          end
          if (mispred) begin
            RoBRS_pre_judge <= 1'b0;
            RoBIF_next_pc   <= npc_q[head_q];
          end
        end
        if (do_alloc) begin
          busy_q[tail_q] <= 1'b1;
          rdy_q[tail_q]  <= 1'b0;
          op_q[tail_q]   <= DPRoB_opcode;
          rd_q[tail_q]   <= DPRoB_rd;
          pred_q[tail_q] <= DPRoB_pred_pc;
          tail_q         <= tail_d;
        end
        unique case ({do_alloc, do_commit})
          2'b10:   cnt_q <= cnt_q + CW'(1);
          2'b01:   cnt_q <= cnt_q - CW'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

endmodule
